// File: rtl/mult_pkg.sv
// Shared types for the multiply issue/complete controller.
// Carries the ALU function encoding used by the multiply path, the request
// payload that travels through the request FIFO, and the controller states.
package mult_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned MULT_TAG_W = 5;

  // Multiply-related ALU function codes; ALU_ADD (0) is the idle/reset encoding.
  typedef enum logic [4:0] {
    ALU_ADD    = 5'h00,
    ALU_MUL    = 5'h0a,
    ALU_MULH   = 5'h0b,
    ALU_MULHSU = 5'h0c,
    ALU_MULHU  = 5'h0d
  } ALU_FUNC;

  typedef struct packed {
    logic [XLEN-1:0]       mcand;
    logic [XLEN-1:0]       mplier;
    ALU_FUNC               func;
    logic [MULT_TAG_W-1:0] tag;
  } mult_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } mult_state_e;

  localparam mult_req_t MULT_REQ_ZERO = '{
    mcand:  {XLEN{1'b0}},
    mplier: {XLEN{1'b0}},
    func:   ALU_ADD,
    tag:    {MULT_TAG_W{1'b0}}
  };

  // An op whose product is trivially zero regardless of function.
  function automatic logic is_zero_op(input mult_req_t req);
    return (req.mcand == {XLEN{1'b0}}) || (req.mplier == {XLEN{1'b0}});
  endfunction

endpackage

// File: rtl/mult_issue_ctrl_fifo.sv
// Request FIFO for the multiply issue controller (module mult_req_fifo).
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// Occupancy is kept in a separate counter; full/empty are registered flags.
module mult_req_fifo
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      clear,
  input  logic      push,
  input  logic      pop,
  input  mult_req_t wdata,
  output mult_req_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  mult_req_t        mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic [PTR_W:0]   count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = full_r;
  assign empty = empty_r;
  assign rdata = mem_r[rd_ptr_r];

  // Qualify push/pop against the flags and work out the next occupancy.
  always_comb begin
    do_push_s    = push && !full_r;
    do_pop_s     = pop && !empty_r;
    count_next_s = count_r;
    if (clear) begin
      count_next_s = {(PTR_W+1){1'b0}};
    end else begin
      case ({do_push_s, do_pop_s})
        2'b10:   count_next_s = count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_next_s = count_r - (PTR_W+1)'(1'b1);
        default: count_next_s = count_r;
      endcase
    end
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      count_r <= count_next_s;
      full_r  <= (count_next_s == (PTR_W+1)'(DEPTH));
      empty_r <= (count_next_s == {(PTR_W+1){1'b0}});
      if (clear) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
        if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
        if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
    end
  end

  // Payload storage; cleared on reset so the head never reads unknown data.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_r[i] <= MULT_REQ_ZERO;
    end else if (do_push_s && !clear) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/complete controller around the multi-cycle multiplier.
// Buffers tagged requests, launches one op at a time with a single-cycle
// start pulse, and holds each product with its tag until the CDB takes it.
// Optional build macro: MULT_ZERO_BYPASS_EN -- ops with a zero operand skip
// the multiplier and go straight to HOLD with a zero product.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = MULT_TAG_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_mcand,
  input  logic [XLEN-1:0]  in_mplier,
  input  ALU_FUNC          in_func,
  input  logic [TAG_W-1:0] in_tag,
  output logic             mul_start,
  output logic [XLEN-1:0]  mul_mcand,
  output logic [XLEN-1:0]  mul_mplier,
  output ALU_FUNC          mul_func,
  input  logic [XLEN-1:0]  mul_product,
  input  logic             mul_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_product,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  mult_state_e      state_r;
  logic             mul_start_r;
  logic [XLEN-1:0]  mul_mcand_r;
  logic [XLEN-1:0]  mul_mplier_r;
  ALU_FUNC          mul_func_r;
  logic             out_valid_r;
  logic [XLEN-1:0]  out_product_r;
  logic [TAG_W-1:0] out_tag_r;
  logic [TAG_W-1:0] cur_tag_r;

  mult_req_t        wreq_s;
  mult_req_t        head_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             push_s;
  logic             launch_s;
  logic             bypass_s;

  assign wreq_s = '{mcand: in_mcand, mplier: in_mplier, func: in_func,
                    tag: MULT_TAG_W'(in_tag)};

  mult_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .push  (push_s),
    .pop   (launch_s),
    .wdata (wreq_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Admission and launch decisions; flush blocks both.
  always_comb begin
    push_s   = in_valid && !fifo_full_s && !flush;
    launch_s = 1'b0;
    case (state_r)
      IDLE:    launch_s = !fifo_empty_s && !flush;
      HOLD:    launch_s = out_ready && !fifo_empty_s && !flush;
      default: launch_s = 1'b0;
    endcase
`ifdef MULT_ZERO_BYPASS_EN
    bypass_s = launch_s && is_zero_op(head_s);
`else
    bypass_s = 1'b0;
`endif
  end

  // Controller FSM with all outward-facing signals registered.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= IDLE;
      mul_start_r   <= 1'b0;
      mul_mcand_r   <= {XLEN{1'b0}};
      mul_mplier_r  <= {XLEN{1'b0}};
      mul_func_r    <= ALU_ADD;
      out_valid_r   <= 1'b0;
      out_product_r <= {XLEN{1'b0}};
      out_tag_r     <= {TAG_W{1'b0}};
      cur_tag_r     <= {TAG_W{1'b0}};
    end else begin
      mul_start_r <= 1'b0;
      if (flush) begin
        // A squashed op still in the multiplier must be waited out in DRAIN;
        // a completion arriving now (even while draining) closes it off.
        out_valid_r <= 1'b0;
        case (state_r)
          BUSY:    state_r <= mul_done ? IDLE : DRAIN;
          DRAIN:   state_r <= mul_done ? IDLE : DRAIN;
          default: state_r <= IDLE;
        endcase
      end else if (launch_s) begin
        if (bypass_s) begin
          out_product_r <= {XLEN{1'b0}};
          out_tag_r     <= TAG_W'(head_s.tag);
          out_valid_r   <= 1'b1;
          state_r       <= HOLD;
        end else begin
          mul_start_r   <= 1'b1;
          mul_mcand_r   <= head_s.mcand;
          mul_mplier_r  <= head_s.mplier;
          mul_func_r    <= head_s.func;
          cur_tag_r     <= TAG_W'(head_s.tag);
          out_valid_r   <= 1'b0;
          state_r       <= BUSY;
        end
      end else begin
        case (state_r)
          BUSY: begin
            if (mul_done) begin
              out_product_r <= mul_product;
              out_tag_r     <= cur_tag_r;
              out_valid_r   <= 1'b1;
              state_r       <= HOLD;
            end else begin
              state_r <= BUSY;
            end
          end
          HOLD: begin
            if (out_ready) begin
              out_valid_r <= 1'b0;
              state_r     <= IDLE;
            end else begin
              state_r <= HOLD;
            end
          end
          DRAIN: begin
            if (mul_done) state_r <= IDLE;
            else          state_r <= DRAIN;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  assign in_ready    = !fifo_full_s;
  assign busy        = (state_r != IDLE) || !fifo_empty_s;
  assign mul_start   = mul_start_r;
  assign mul_mcand   = mul_mcand_r;
  assign mul_mplier  = mul_mplier_r;
  assign mul_func    = mul_func_r;
  assign out_valid   = out_valid_r;
  assign out_product = out_product_r;
  assign out_tag     = out_tag_r;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl with a behavioural multi-cycle
// multiplier (start -> done after four clocks) wired back to back.
module tb_mult_issue_ctrl;
  import mult_pkg::*;

  logic            clock;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_mcand;
  logic [63:0]     in_mplier;
  ALU_FUNC         in_func;
  logic [4:0]      in_tag;
  logic            mul_start;
  logic [63:0]     mul_mcand;
  logic [63:0]     mul_mplier;
  ALU_FUNC         mul_func;
  logic [63:0]     mul_product;
  logic            mul_done;
  logic            out_valid;
  logic            out_ready;
  logic [63:0]     out_product;
  logic [4:0]      out_tag;
  logic            busy;

  int checks = 0;
  int errors = 0;

  mult_issue_ctrl #(.DEPTH(4), .TAG_W(5)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_mcand(in_mcand),
    .in_mplier(in_mplier), .in_func(in_func), .in_tag(in_tag),
    .mul_start(mul_start), .mul_mcand(mul_mcand), .mul_mplier(mul_mplier),
    .mul_func(mul_func), .mul_product(mul_product), .mul_done(mul_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .out_tag(out_tag), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural multiplier stand-in.
  function automatic logic [63:0] mul_model(input logic [63:0] a, input logic [63:0] b,
                                            input ALU_FUNC f);
    logic [127:0] ea, eb, p;
    ea = ((f == ALU_MULH) || (f == ALU_MULHSU)) ? {{64{a[63]}}, a} : {64'd0, a};
    eb = (f == ALU_MULH) ? {{64{b[63]}}, b} : {64'd0, b};
    p  = ea * eb;
    return (f == ALU_MUL) ? p[63:0] : p[127:64];
  endfunction

  logic [2:0]  m_cnt;
  logic [63:0] m_prod;
  always @(posedge clock) begin
    if (!reset) begin
      m_cnt <= 3'd0; m_prod <= 64'd0; mul_done <= 1'b0; mul_product <= 64'd0;
    end else if (mul_start) begin
      m_cnt <= 3'd3; m_prod <= mul_model(mul_mcand, mul_mplier, mul_func); mul_done <= 1'b0;
    end else if (m_cnt != 3'd0) begin
      m_cnt <= m_cnt - 3'd1;
      mul_done <= (m_cnt == 3'd1);
      if (m_cnt == 3'd1) mul_product <= m_prod;
    end else begin
      mul_done <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
    in_valid = 1'b1; in_mcand = a; in_mplier = b; in_func = ALU_MUL; in_tag = t;
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
    chk(tag, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic wait_mul_done(input string tag);
    int n = 0;
    while (mul_done !== 1'b1 && n < 40) begin step(); n++; end
    chk(tag, {63'd0, mul_done}, 64'd1);
  endtask

  logic [63:0] exp_prod [5];
  logic        saw_bad;

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(64'd9, 64'd9, 5'd3);

    // 1. reset held three cycles with in_valid high
    step(); step(); step();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_mul_start", {63'd0, mul_start}, 64'd0);
    chk("rst_mul_mcand", mul_mcand, 64'd0);
    chk("rst_mul_mplier", mul_mplier, 64'd0);
    chk("rst_mul_func", {59'd0, mul_func}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_product", out_product, 64'd0);
    chk("rst_out_tag", {59'd0, out_tag}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1; in_valid = 1'b0;
    step();
    chk("post_rst_busy", {63'd0, busy}, 64'd0);

    // 2. single op 2*3, tag 7
    drive(64'd2, 64'd3, 5'd7);
    step();
    in_valid = 1'b0;
    chk("t2_no_start_yet", {63'd0, mul_start}, 64'd0);
    chk("t2_busy", {63'd0, busy}, 64'd1);
    step();
    chk("t2_start", {63'd0, mul_start}, 64'd1);
    chk("t2_mcand", mul_mcand, 64'd2);
    chk("t2_mplier", mul_mplier, 64'd3);
    chk("t2_func", {59'd0, mul_func}, {59'd0, ALU_MUL});
    step();
    chk("t2_start_pulse", {63'd0, mul_start}, 64'd0);
    chk("t2_mcand_held", mul_mcand, 64'd2);
    wait_out_valid("t2_out_valid");
    chk("t2_product", out_product, 64'd6);
    chk("t2_tag", {59'd0, out_tag}, 64'd7);
    for (int i = 0; i < 5; i++) step();
    chk("t2_hold_valid", {63'd0, out_valid}, 64'd1);
    chk("t2_hold_product", out_product, 64'd6);
    chk("t2_hold_tag", {59'd0, out_tag}, 64'd7);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t2_valid_drop", {63'd0, out_valid}, 64'd0);
    chk("t2_idle_busy", {63'd0, busy}, 64'd0);

    // 3. five ops back to back against a four-entry FIFO
    exp_prod[0] = 64'd250;
    exp_prod[1] = 64'hFFFF_FFFF_FFFF_FFFD;
    exp_prod[2] = 64'd56;
    exp_prod[3] = 64'd100;
    exp_prod[4] = 64'd81;
    drive(64'd5, 64'd50, 5'd1);                  step();
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 5'd2); step();
    drive(64'd7, 64'd8, 5'd3);                   step();
    drive(64'd10, 64'd10, 5'd4);                 step();
    drive(64'd9, 64'd9, 5'd5);                   step();
    chk("t3_full", {63'd0, in_ready}, 64'd0);
    drive(64'd11, 64'd11, 5'd31);
    step(); step();
    chk("t3_still_full", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_out_valid("t3_out_valid");
      chk("t3_product", out_product, exp_prod[i]);
      chk("t3_tag", {59'd0, out_tag}, 64'(i + 1));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("t3_next_start", {63'd0, mul_start}, (i < 4) ? 64'd1 : 64'd0);
      chk("t3_valid_drop", {63'd0, out_valid}, 64'd0);
    end
    chk("t3_idle_busy", {63'd0, busy}, 64'd0);
    chk("t3_in_ready", {63'd0, in_ready}, 64'd1);

    // 4. flush while all-ones squared is in flight
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9);
    step();
    in_valid = 1'b0;
    step();
    chk("t4_start", {63'd0, mul_start}, 64'd1);
    step(); step();
    flush = 1'b1;
    drive(64'd3, 64'd3, 5'd11);
    step();
    flush = 1'b0;
    chk("t4_drain_busy", {63'd0, busy}, 64'd1);
    chk("t4_drain_valid", {63'd0, out_valid}, 64'd0);
    drive(64'd5, 64'd5, 5'd10);
    step();
    in_valid = 1'b0;
    saw_bad = 1'b0;
    for (int n = 0; n < 20 && mul_start !== 1'b1; n++) begin
      if (out_valid !== 1'b0) saw_bad = 1'b1;
      step();
    end
    chk("t4_no_squashed_result", {63'd0, saw_bad}, 64'd0);
    chk("t4_relaunch", {63'd0, mul_start}, 64'd1);
    chk("t4_relaunch_mcand", mul_mcand, 64'd5);
    wait_out_valid("t4_out_valid");
    chk("t4_product", out_product, 64'd25);
    chk("t4_tag", {59'd0, out_tag}, 64'd10);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_idle_busy", {63'd0, busy}, 64'd0);

    // 5. flush together with mul_done and out_ready, second op queued
    drive(64'd4, 64'd4, 5'd12); step();
    drive(64'd6, 64'd6, 5'd13); step();
    in_valid = 1'b0;
    wait_mul_done("t5_done");
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    chk("t5_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    chk("t5_in_ready", {63'd0, in_ready}, 64'd1);
    step(); step();
    chk("t5_no_launch", {63'd0, mul_start}, 64'd0);
    chk("t5_still_invalid", {63'd0, out_valid}, 64'd0);

    // 5b. flush in HOLD with out_ready high
    drive(64'd2, 64'd2, 5'd14); step();
    in_valid = 1'b0;
    wait_out_valid("t5b_out_valid");
    chk("t5b_product", out_product, 64'd4);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0; out_ready = 1'b0;
    chk("t5b_valid", {63'd0, out_valid}, 64'd0);
    chk("t5b_busy", {63'd0, busy}, 64'd0);

    // 6. zero operand
    drive(64'd0, 64'd257, 5'd15);
    step();
    in_valid = 1'b0;
    step();
`ifdef MULT_ZERO_BYPASS_EN
    chk("t6_no_start", {63'd0, mul_start}, 64'd0);
    chk("t6_valid", {63'd1 & 63'd0, out_valid}, 64'd1);
`else
    chk("t6_start", {63'd0, mul_start}, 64'd1);
    wait_out_valid("t6_valid");
`endif
    chk("t6_product", out_product, 64'd0);
    chk("t6_tag", {59'd0, out_tag}, 64'd15);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_idle", {63'd0, busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
